// File: rtl/k_dsp_pkg.sv
// k_dsp_pkg
// Shared definitions for the k_dsp execute unit:
//   - op_t            : opcode encodings (OP_ADD..OP_RDACC); 6 and 7 are illegal
//   - DEFAULT_W       : default operand/result width
//   - DEFAULT_ACC_W   : default accumulator width (at least 2*W)
//   - signed_max/min  : constant functions giving the two's complement
//                       limits of an n-bit value, zero-extended to MAX_SAT_W
package k_dsp_pkg;

  localparam int DEFAULT_W     = 32;
  localparam int DEFAULT_ACC_W = 64;
  localparam int MAX_SAT_W     = 256;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_MAC   = 3'd3,
    OP_CLR   = 3'd4,
    OP_RDACC = 3'd5
  } op_t;

  // Largest signed n-bit value: 0111...1 in the low n bits.
  function automatic logic [MAX_SAT_W-1:0] signed_max(input int n);
    logic [MAX_SAT_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_SAT_W; i++) begin
      if (i < n - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Smallest signed n-bit value: 1000...0 in the low n bits.
  function automatic logic [MAX_SAT_W-1:0] signed_min(input int n);
    logic [MAX_SAT_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_SAT_W; i++) begin
      if (i == n - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/k_dsp_sat.sv
// k_dsp_sat
// Narrows a wide two's complement value to OUT_W bits. ovf flags that the
// value is not representable in OUT_W signed bits. With SAT set the output
// clamps to the signed OUT_W max/min on overflow, otherwise it wraps
// (plain truncation).
// Ports:
//   value   in  IN_W   wide signed value (IN_W > OUT_W)
//   clamped out OUT_W  narrowed value
//   ovf     out 1      value does not fit in OUT_W signed bits
module k_dsp_sat
  import k_dsp_pkg::*;
#(
  parameter int IN_W  = 65,
  parameter int OUT_W = 64,
  parameter bit SAT   = 1'b0
) (
  input  logic [IN_W-1:0]  value,
  output logic [OUT_W-1:0] clamped,
  output logic             ovf
);

  localparam logic [OUT_W-1:0] MAX_V = OUT_W'(signed_max(OUT_W));
  localparam logic [OUT_W-1:0] MIN_V = OUT_W'(signed_min(OUT_W));

  // The value fits exactly when every bit from the OUT_W sign bit upward
  // is a copy of the same sign.
  logic [IN_W-OUT_W:0] upper;
  assign upper = value[IN_W-1:OUT_W-1];
  assign ovf   = (|upper) && !(&upper);

  always_comb begin
    clamped = value[OUT_W-1:0];
    if (SAT && ovf) clamped = value[IN_W-1] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/k_dsp_exec_unit.sv
// k_dsp_exec_unit
// Two-stage signed ADD/SUB/MUL/MAC execute unit with one architectural
// accumulator, valid/ready on both sides, one result per accepted op, in order.
//   S1: registers op/operands and the full 2W-bit signed product.
//   S2: output register; forms the final result and commits the acc update.
// Optional feature: define K_DSP_SAT_EN to saturate instead of wrap
// (ADD/SUB/MUL clamp to signed W; MAC clamps acc to signed ACC_W, then the
// result to signed W). ovf reporting is identical in both builds.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready independent of in_valid)
//   op, rs1, rs2        opcode and operands
//   out_valid/out_ready output handshake
//   result, ovf, err    result, overflow/saturation flag, illegal-op flag
module k_dsp_exec_unit
  import k_dsp_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         err
);

`ifdef K_DSP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                    s1_v;
  logic [2:0]              s1_op;
  logic signed [W-1:0]     s1_a;
  logic signed [W-1:0]     s1_b;
  logic signed [2*W-1:0]   s1_prod;
  logic                    s2_v;
  logic signed [ACC_W-1:0] acc;

  logic advance;

  assign advance   = !s2_v || out_ready;
  assign in_ready  = !s1_v || advance;
  assign out_valid = s2_v;

  // S1 loads whenever it is empty or draining into S2; the product is
  // formed on the way in so S2 only has to add and narrow.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_op   <= '0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_prod <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_op   <= op;
        s1_a    <= rs1;
        s1_b    <= rs2;
        s1_prod <= (2*W)'($signed(rs1)) * (2*W)'($signed(rs2));
      end
    end
  end

  logic signed [W:0]       add_sum;
  logic signed [W:0]       sub_diff;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0]        mac_acc;
  logic                    mac_acc_ovf;

  // One guard bit on ADD/SUB and on the accumulator add lets the narrowing
  // stage see the exact value.
  assign add_sum  = (W+1)'(s1_a) + (W+1)'(s1_b);
  assign sub_diff = (W+1)'(s1_a) - (W+1)'(s1_b);
  assign prod_ext = ACC_W'(s1_prod);
  assign acc_sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_ext);

`ifdef K_DSP_SAT_EN
  k_dsp_sat #(.IN_W(ACC_W+1), .OUT_W(ACC_W), .SAT(1'b1)) u_acc_sat (
    .value   (acc_sum),
    .clamped (mac_acc),
    .ovf     (mac_acc_ovf)
  );
`else
  assign mac_acc     = acc_sum[ACC_W-1:0];
  assign mac_acc_ovf = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
`endif

  logic [ACC_W-1:0] res_wide;
  logic [W-1:0]     res_val;
  logic             res_ovf;

  // Every opcode presents a sign-extended ACC_W value to a single narrowing
  // instance. RDACC feeds only the low W acc bits so it never reports ovf;
  // CLR and the illegal opcodes present zero.
  always_comb begin
    res_wide = '0;
    case (s1_op)
      OP_ADD:   res_wide = ACC_W'(add_sum);
      OP_SUB:   res_wide = ACC_W'(sub_diff);
      OP_MUL:   res_wide = ACC_W'(s1_prod);
      OP_MAC:   res_wide = mac_acc;
      OP_RDACC: res_wide = ACC_W'($signed(acc[W-1:0]));
      default:  res_wide = '0;
    endcase
  end

  k_dsp_sat #(.IN_W(ACC_W), .OUT_W(W), .SAT(SAT)) u_res_sat (
    .value   (res_wide),
    .clamped (res_val),
    .ovf     (res_ovf)
  );

  // S2 and the accumulator move only on advance, so a stalled result holds
  // and its acc update is applied exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      acc    <= '0;
    end else if (advance) begin
      s2_v <= s1_v;
      if (s1_v) begin
        result <= res_val;
        ovf    <= res_ovf || ((s1_op == OP_MAC) && mac_acc_ovf);
        // Opcodes 6 and 7 are the only ones with both top bits set.
        err    <= (s1_op[2:1] == 2'b11);
        if (s1_op == OP_MAC) acc <= mac_acc;
        else if (s1_op == OP_CLR) acc <= '0;
      end
    end
  end

endmodule
